// File: rtl/freq_gen_pkg.sv
// Shared types for the programmable square-wave generator.
// FREQ_GEN_BURST_EN adds a per-config burst length to the config record.
package freq_gen_pkg;

    localparam int DEFAULT_CNT_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    // Fields are sized for the widest supported counter; narrower builds truncate.
    typedef struct packed {
        logic [DEFAULT_CNT_WIDTH-1:0] high;
        logic [DEFAULT_CNT_WIDTH-1:0] low;
`ifdef FREQ_GEN_BURST_EN
        logic [15:0]                  burst_len;
`endif
    } cfg_t;

endpackage

// File: rtl/freq_gen_phase_counter.sv
// Loadable down-counter; tc flags the last cycle of the loaded phase.
module freq_gen_phase_counter
    import freq_gen_pkg::*;
#(
    parameter int CNT_WIDTH = DEFAULT_CNT_WIDTH
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 load,
    input  logic [CNT_WIDTH-1:0] load_val,
    output logic                 tc
);

    logic [CNT_WIDTH-1:0] cnt_q;

    // Loaded with length-1, so a phase of N cycles ends when the count reaches zero.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_WIDTH'(1);
        end
    end

    assign tc = (cnt_q == '0);

endmodule

// File: rtl/freq_generator.sv
// Programmable square-wave source; new settings apply only on period boundaries.
// Optional FREQ_GEN_BURST_EN: BURST_LEN input limits each config to a finite burst.
module freq_generator
    import freq_gen_pkg::*;
#(
    parameter int CNT_WIDTH = DEFAULT_CNT_WIDTH
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 EN,
    input  logic                 CFG_VALID,
    output logic                 CFG_READY,
    input  logic [CNT_WIDTH-1:0] CFG_HIGH,
    input  logic [CNT_WIDTH-1:0] CFG_LOW,
`ifdef FREQ_GEN_BURST_EN
    input  logic [15:0]          BURST_LEN,
`endif
    output logic                 FREQ_OUT,
    output logic                 BUSY,
    output logic                 PERIOD_DONE,
    output logic [CNT_WIDTH-1:0] PERIOD_COUNT
);

    state_t               state_q, state_d;
    cfg_t                 act_q, act_d, pend_q, cfg_in, new_cfg, start_cfg;
    logic                 pend_vld_q;
    logic                 freq_q, freq_d;
    logic [CNT_WIDTH-1:0] period_cnt_q;
    logic                 hs, avail, take, boundary, done, go_start, burst_over;
    logic                 load, tc;
    logic [CNT_WIDTH-1:0] load_val, act_lo, st_hi, st_lo, start_val;
    state_t               start_state;

    assign hs    = CFG_VALID && !pend_vld_q;
    assign avail = pend_vld_q || hs;

    always_comb begin
        cfg_in      = '0;
        cfg_in.high = DEFAULT_CNT_WIDTH'(CFG_HIGH);
        cfg_in.low  = DEFAULT_CNT_WIDTH'(CFG_LOW);
`ifdef FREQ_GEN_BURST_EN
        cfg_in.burst_len = BURST_LEN;
`endif
    end

    // A same-edge handshake bypasses the pending slot when the slot is empty.
    assign new_cfg   = pend_vld_q ? pend_q : cfg_in;
    assign start_cfg = avail ? new_cfg : act_q;

    assign act_lo = CNT_WIDTH'(act_q.low);
    assign st_hi  = CNT_WIDTH'(start_cfg.high);
    assign st_lo  = CNT_WIDTH'(start_cfg.low);

    // Zero-length phases are skipped; both zero means stop.
    always_comb begin
        if (st_hi != '0) begin
            start_state = HIGH;
            start_val   = st_hi - CNT_WIDTH'(1);
        end else if (st_lo != '0) begin
            start_state = LOW;
            start_val   = st_lo - CNT_WIDTH'(1);
        end else begin
            start_state = IDLE;
            start_val   = '0;
        end
    end

`ifdef FREQ_GEN_BURST_EN
    logic [15:0] burst_cnt_q;
    assign burst_over = (act_q.burst_len != 16'd0) &&
                        (burst_cnt_q == act_q.burst_len - 16'd1);
`else
    assign burst_over = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        act_d    = act_q;
        freq_d   = freq_q;
        load     = 1'b0;
        load_val = '0;
        take     = 1'b0;
        boundary = 1'b0;
        go_start = 1'b0;

        case (state_q)
            IDLE: begin
                if (EN && avail) begin
                    take     = 1'b1;
                    go_start = 1'b1;
                end
            end
            HIGH: begin
                if (tc) begin
                    if (act_lo != '0) begin
                        state_d  = LOW;
                        freq_d   = 1'b0;
                        load     = 1'b1;
                        load_val = act_lo - CNT_WIDTH'(1);
                    end else begin
                        boundary = 1'b1;
                    end
                end
            end
            LOW: begin
                if (tc) boundary = 1'b1;
            end
            default: begin
                state_d = IDLE;
                freq_d  = 1'b0;
            end
        endcase

        if (boundary) begin
            if (!EN || (!avail && burst_over)) begin
                state_d = IDLE;
                freq_d  = 1'b0;
            end else begin
                take     = avail;
                go_start = 1'b1;
            end
        end

        if (go_start) begin
            state_d  = start_state;
            act_d    = start_cfg;
            freq_d   = (start_state == HIGH);
            load     = 1'b1;
            load_val = start_val;
        end
    end

    assign done = boundary;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= IDLE;
            act_q        <= '0;
            pend_q       <= '0;
            pend_vld_q   <= 1'b0;
            freq_q       <= 1'b0;
            period_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            act_q   <= act_d;
            freq_q  <= freq_d;
            if (done) period_cnt_q <= period_cnt_q + CNT_WIDTH'(1);
            if (pend_vld_q && take) begin
                pend_vld_q <= 1'b0;
            end else if (hs && !take) begin
                pend_vld_q <= 1'b1;
                pend_q     <= cfg_in;
            end
        end
    end

`ifdef FREQ_GEN_BURST_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            burst_cnt_q <= 16'd0;
        end else if (take) begin
            burst_cnt_q <= 16'd0;
        end else if (boundary && EN) begin
            burst_cnt_q <= burst_cnt_q + 16'd1;
        end
    end
`endif

    freq_gen_phase_counter #(.CNT_WIDTH(CNT_WIDTH)) u_phase (
        .CLK      (CLK),
        .RST      (RST),
        .load     (load),
        .load_val (load_val),
        .tc       (tc)
    );

    assign FREQ_OUT     = freq_q;
    assign CFG_READY    = !pend_vld_q;
    assign BUSY         = (state_q != IDLE);
    assign PERIOD_DONE  = done;
    assign PERIOD_COUNT = period_cnt_q;

endmodule

// File: tb/tb_freq_generator.sv
// Directed bench for freq_generator; burst checks run when FREQ_GEN_BURST_EN is defined.
module tb_freq_generator;

    logic        CLK;
    logic        RST;
    logic        EN;
    logic        CFG_VALID;
    logic        CFG_READY;
    logic [31:0] CFG_HIGH;
    logic [31:0] CFG_LOW;
`ifdef FREQ_GEN_BURST_EN
    logic [15:0] BURST_LEN;
`endif
    logic        FREQ_OUT;
    logic        BUSY;
    logic        PERIOD_DONE;
    logic [31:0] PERIOD_COUNT;

    int n_cmp = 0;
    int n_bad = 0;

    freq_generator #(.CNT_WIDTH(32)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .EN           (EN),
        .CFG_VALID    (CFG_VALID),
        .CFG_READY    (CFG_READY),
        .CFG_HIGH     (CFG_HIGH),
        .CFG_LOW      (CFG_LOW),
`ifdef FREQ_GEN_BURST_EN
        .BURST_LEN    (BURST_LEN),
`endif
        .FREQ_OUT     (FREQ_OUT),
        .BUSY         (BUSY),
        .PERIOD_DONE  (PERIOD_DONE),
        .PERIOD_COUNT (PERIOD_COUNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST       = 1'b1;
        EN        = 1'b0;
        CFG_VALID = 1'b0;
        step();
        step();
        RST = 1'b0;
    endtask

    // Returns at the first sample after the handshake edge.
    task automatic send_cfg(input logic [31:0] h, input logic [31:0] l);
        int w;
        w = 0;
        CFG_VALID = 1'b1;
        CFG_HIGH  = h;
        CFG_LOW   = l;
        while (!CFG_READY && w < 50) begin
            step();
            w++;
        end
        if (!CFG_READY) check("cfg_ready_timeout", 32'(CFG_READY), 32'd1);
        step();
        CFG_VALID = 1'b0;
    endtask

    // Expected waveform: high for p<h, done on the last cycle of each h+l period.
    task automatic check_wave(input string tag, input int h, input int l, input int n, input int p0);
        for (int i = 0; i < n; i++) begin
            int p;
            p = (p0 + i) % (h + l);
            check({tag, "_out"},  32'(FREQ_OUT),    32'(p < h));
            check({tag, "_done"}, 32'(PERIOD_DONE), 32'(p == h + l - 1));
            step();
        end
    endtask

    initial begin
        int th, tl;
`ifdef FREQ_GEN_BURST_EN
        int ndone;
        BURST_LEN = 16'd0;
`endif
        RST       = 1'b1;
        EN        = 1'b0;
        CFG_VALID = 1'b0;
        CFG_HIGH  = '0;
        CFG_LOW   = '0;

        // reset state
        do_reset();
        check("rst_out",   32'(FREQ_OUT),    32'd0);
        check("rst_ready", 32'(CFG_READY),   32'd1);
        check("rst_busy",  32'(BUSY),        32'd0);
        check("rst_done",  32'(PERIOD_DONE), 32'd0);
        check("rst_count", PERIOD_COUNT,     32'd0);

        // H=3 L=5 continuous, then mid-high reconfiguration to 2/2
        EN = 1'b1;
        send_cfg(32'd3, 32'd5);
        check("p35_busy", 32'(BUSY), 32'd1);
        check_wave("p35", 3, 5, 32, 0);
        check("p35_count", PERIOD_COUNT, 32'd4);
        CFG_VALID = 1'b1;
        CFG_HIGH  = 32'd2;
        CFG_LOW   = 32'd2;
        check_wave("mid", 3, 5, 1, 0);
        CFG_VALID = 1'b0;
        check("mid_ready_lo", 32'(CFG_READY), 32'd0);
        check_wave("mid", 3, 5, 7, 1);
        check("mid_ready_hi", 32'(CFG_READY), 32'd1);
        check("mid_count", PERIOD_COUNT, 32'd5);
        check_wave("p22", 2, 2, 8, 0);
        check("p22_count", PERIOD_COUNT, 32'd7);

        // H=0 L=4: constant low
        do_reset();
        EN = 1'b1;
        send_cfg(32'd0, 32'd4);
        check("h0_busy", 32'(BUSY), 32'd1);
        check_wave("h0", 0, 4, 12, 0);
        check("h0_count", PERIOD_COUNT, 32'd3);

        // H=4 L=0: constant high, then 0/0 loaded at boundary stops
        do_reset();
        EN = 1'b1;
        send_cfg(32'd4, 32'd0);
        check_wave("l0", 4, 0, 8, 0);
        CFG_VALID = 1'b1;
        CFG_HIGH  = 32'd0;
        CFG_LOW   = 32'd0;
        check_wave("l0", 4, 0, 1, 0);
        CFG_VALID = 1'b0;
        check_wave("l0", 4, 0, 3, 1);
        check("stop_busy",  32'(BUSY),        32'd0);
        check("stop_out",   32'(FREQ_OUT),    32'd0);
        check("stop_done",  32'(PERIOD_DONE), 32'd0);
        check("stop_count", PERIOD_COUNT,     32'd3);
        step();
        step();
        check("stop_hold_busy", 32'(BUSY), 32'd0);

        // 0/0 from IDLE with EN=1
        do_reset();
        EN = 1'b1;
        send_cfg(32'd0, 32'd0);
        step();
        check("zz_busy",  32'(BUSY),      32'd0);
        check("zz_out",   32'(FREQ_OUT),  32'd0);
        check("zz_ready", 32'(CFG_READY), 32'd1);

        // EN dropped in cycle 2 of a 4/4 period: period completes
        do_reset();
        EN = 1'b1;
        send_cfg(32'd4, 32'd4);
        check_wave("en", 4, 4, 1, 0);
        EN = 1'b0;
        check_wave("en", 4, 4, 7, 1);
        check("en_busy",  32'(BUSY),     32'd0);
        check("en_out",   32'(FREQ_OUT), 32'd0);
        check("en_count", PERIOD_COUNT,  32'd1);
        step();
        check("en_idle_done", 32'(PERIOD_DONE), 32'd0);

        // asynchronous reset during the high phase
        EN = 1'b1;
        send_cfg(32'd4, 32'd4);
        step();
        check("prerst_out", 32'(FREQ_OUT), 32'd1);
        #2;
        RST = 1'b1;
        #1;
        check("arst_out",   32'(FREQ_OUT),  32'd0);
        check("arst_count", PERIOD_COUNT,   32'd0);
        check("arst_busy",  32'(BUSY),      32'd0);
        check("arst_ready", 32'(CFG_READY), 32'd1);
        step();
        RST = 1'b0;
        for (int i = 0; i < 6; i++) step();
        check("arst_noresume_busy", 32'(BUSY),     32'd0);
        check("arst_noresume_out",  32'(FREQ_OUT), 32'd0);

        // loopback measurement with H=10 L=6
        do_reset();
        EN = 1'b1;
        send_cfg(32'd10, 32'd6);
        th = 0;
        while (FREQ_OUT && th < 100) begin
            th++;
            step();
        end
        tl = 0;
        while (!FREQ_OUT && tl < 100) begin
            tl++;
            step();
        end
        check("loop_time_high", 32'(th),      32'd10);
        check("loop_time_low",  32'(tl),      32'd6);
        check("loop_period",    32'(th + tl), 32'd16);

`ifdef FREQ_GEN_BURST_EN
        // burst of 3 periods of 2/2, then IDLE despite EN=1
        do_reset();
        EN        = 1'b1;
        BURST_LEN = 16'd3;
        send_cfg(32'd2, 32'd2);
        ndone = 0;
        for (int i = 0; i < 20; i++) begin
            if (PERIOD_DONE) ndone++;
            step();
        end
        check("burst_pulses", 32'(ndone),  32'd3);
        check("burst_busy",   32'(BUSY),   32'd0);
        check("burst_count",  PERIOD_COUNT, 32'd3);
        BURST_LEN = 16'd0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/freq_generator.md
# freq_generator

Programmable square-wave source that drives a signal high for a configured number of clock cycles and low for another, repeating continuously. It is the stimulus-side counterpart of the frequency measurement path: when its output feeds the frequency counter, that block reports TIME_HIGH/TIME_LOW equal to the programmed values and PERIOD equal to their sum. New settings arrive through a valid/ready handshake and take effect only on period boundaries, so the output never shows a partial period.

## Interface
- CNT_WIDTH, 32, width of phase durations and period counter
- CLK  in  1  system clock, all logic on rising edge
- RST  in  1  asynchronous, active-high reset
- EN  in  1  run enable; level-sensitive
- CFG_VALID  in  1  configuration offered
- CFG_READY  out  1  configuration slot free
- CFG_HIGH  in  CNT_WIDTH  high-phase length, clock cycles
- CFG_LOW  in  CNT_WIDTH  low-phase length, clock cycles
- FREQ_OUT  out  1  generated waveform, registered
- BUSY  out  1  state is not IDLE
- PERIOD_DONE  out  1  one-cycle pulse in the final cycle of each period
- PERIOD_COUNT  out  CNT_WIDTH  completed periods since reset, wraps

## Operation
- Reset values: FREQ_OUT=0, CFG_READY=1, BUSY=0, PERIOD_DONE=0, PERIOD_COUNT=0; state IDLE; pending and active config cleared.
- Two config registers: pending (one slot, filled by handshake) and active (drives counting). CFG_READY = pending slot empty.
- Handshake completes on an edge where CFG_VALID & CFG_READY; CFG_VALID held with CFG_READY=0 is stalled, not dropped.
- States: IDLE, HIGH, LOW.
- IDLE -> HIGH: EN=1 and config available (pending, or handshake this edge, bypassing pending). Config copied to active; FREQ_OUT=1.
- HIGH -> LOW after active.high cycles; LOW -> boundary after active.low cycles.
- At boundary: if EN=0 -> IDLE, FREQ_OUT=0. Else load pending (or same-edge handshake) into active if present, otherwise reuse active; enter HIGH.
- EN deasserted mid-period: current period completes; no truncation.
- Zero lengths: high=0 -> HIGH skipped, output constant low, period = low; low=0 -> LOW skipped, output constant high, period = high; both 0 -> treated as stop, return to IDLE with FREQ_OUT=0, no PERIOD_DONE.
- PERIOD_COUNT increments on each PERIOD_DONE; 2^CNT_WIDTH-1 wraps to 0.
- Arithmetic: unsigned, CNT_WIDTH; phase counter never exceeds programmed value; no sum of high+low is formed.

## Timing
- Handshake at edge k from IDLE with EN=1: FREQ_OUT=1 for cycles k+1..k+H, 0 for k+H+1..k+H+L, next rise k+H+L+1.
- PERIOD_DONE asserted in cycle k+H+L (last low cycle); PERIOD_COUNT updated after that edge.
- Config accepted during a period: effective from the next rise; zero cycles of mixed settings.
- Handshake on the boundary edge itself: new config applied to the period starting that edge.
- RST asserted mid-period: FREQ_OUT drops to 0 asynchronously; all state as reset values; resumes only after new handshake.

## Configuration
- FREQ_GEN_BURST_EN defined: adds input BURST_LEN [15:0], captured with each config. Nonzero -> generator runs exactly BURST_LEN periods then returns to IDLE (even with EN=1) until a new handshake; 0 -> continuous. A config loaded at a boundary restarts the burst count.
- Undefined: BURST_LEN port absent; generation continuous while EN=1.

## Structure
- Package freq_gen_pkg: state enum (IDLE, HIGH, LOW), default CNT_WIDTH constant, config struct {high, low[, burst_len]}.
- One sub-module: freq_gen_phase_counter — loadable down-counter with terminal-count flag, instantiated once and reloaded per phase.

## Test plan
- H=3, L=5, EN=1: FREQ_OUT 3 high / 5 low repeating; PERIOD_DONE every 8 cycles; PERIOD_COUNT=4 after 32 cycles.
- Running H=3,L=5; offer H=2,L=2 mid-high: CFG_READY drops, current 8-cycle period completes, next period 2/2, CFG_READY returns 1.
- H=0,L=4 -> output constant 0, PERIOD_DONE every 4 cycles; H=4,L=0 -> constant 1, PERIOD_DONE every 4; H=0,L=0 -> IDLE, BUSY=0.
- EN low during cycle 2 of H=4,L=4: period finishes at cycle 8, then IDLE, FREQ_OUT=0; RST mid-high: FREQ_OUT=0 immediately, PERIOD_COUNT=0.
- Loopback to frequency counter with H=10,L=6: it reports TIME_HIGH=10, TIME_LOW=6, PERIOD=16.
- With FREQ_GEN_BURST_EN, BURST_LEN=3, H=L=2: exactly 3 PERIOD_DONE pulses, then IDLE despite EN=1.
